// File: rtl/color_mask_window_buffer_if.sv
// Pixel-stream input / neighbourhood-window output bundle for color_mask_window_buffer.
// The out_x/out_y coordinate signals exist only when WINDOW_COORD_EN is defined.
interface color_mask_window_buffer_if #(
  parameter int unsigned N_SIZE     = 5,
  parameter int unsigned COLORS     = 2
`ifdef WINDOW_COORD_EN
  ,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
`endif
);
  logic [COLORS:0] in_pix;
  logic            in_en;
  logic            in_sof;
  logic [COLORS:0] out_img [0:N_SIZE-1][0:N_SIZE-1];
  logic            out_en;
  logic            frame_done;
`ifdef WINDOW_COORD_EN
  logic [$clog2(IMG_WIDTH)-1:0]  out_x;
  logic [$clog2(IMG_HEIGHT)-1:0] out_y;

  modport master (
    output in_pix, in_en, in_sof,
    input  out_img, out_en, frame_done, out_x, out_y
  );
  modport slave (
    input  in_pix, in_en, in_sof,
    output out_img, out_en, frame_done, out_x, out_y
  );
`else
  modport master (
    output in_pix, in_en, in_sof,
    input  out_img, out_en, frame_done
  );
  modport slave (
    input  in_pix, in_en, in_sof,
    output out_img, out_en, frame_done
  );
`endif
endinterface

// File: rtl/color_mask_window_buffer.sv
// Raster line buffers plus N_SIZE x N_SIZE register window feeding the color-mask denoiser.
// Optional WINDOW_COORD_EN adds registered window-centre coordinates out_x/out_y.
module color_mask_window_buffer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned N_SIZE     = 5,
  parameter int unsigned COLORS     = 2
) (
  input logic                      clk,
  input logic                      reset,
  color_mask_window_buffer_if.slave bus
);
  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  typedef logic [COLORS:0] pix_t;

  // Line buffer 0 holds the previous line, buffer N_SIZE-2 the oldest one.
  pix_t lb_mem [0:N_SIZE-2][0:IMG_WIDTH-1];
  pix_t lb_rd  [0:N_SIZE-2];

  pix_t            win_q [0:N_SIZE-1][0:N_SIZE-1];
  pix_t            win_d [0:N_SIZE-1][0:N_SIZE-1];
  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic            out_en_q, out_en_d;
  logic            frame_done_q, frame_done_d;
  logic            last_col, last_row;
`ifdef WINDOW_COORD_EN
  localparam int unsigned Half = N_SIZE / 2;
  logic [ColW-1:0] x_q, x_d;
  logic [RowW-1:0] y_q, y_d;
`endif

  always_comb begin
    col_cur      = bus.in_sof ? '0 : col_q;
    row_cur      = bus.in_sof ? '0 : row_q;
    for (int unsigned k = 0; k < N_SIZE - 1; k++) begin
      lb_rd[k] = lb_mem[k][col_cur];
    end
    last_col     = (col_cur == ColW'(IMG_WIDTH - 1));
    last_row     = (row_cur == RowW'(IMG_HEIGHT - 1));
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    out_en_d     = 1'b0;
    frame_done_d = 1'b0;
`ifdef WINDOW_COORD_EN
    x_d          = x_q;
    y_d          = y_q;
`endif
    if (bus.in_en) begin
      for (int unsigned i = 0; i < N_SIZE; i++) begin
        for (int unsigned j = 0; j < N_SIZE - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      // Newest column: oldest line at the top, incoming pixel at the bottom.
      for (int unsigned i = 0; i < N_SIZE - 1; i++) begin
        win_d[i][N_SIZE-1] = lb_rd[N_SIZE-2-i];
      end
      win_d[N_SIZE-1][N_SIZE-1] = bus.in_pix;
      out_en_d     = (row_cur >= RowW'(N_SIZE - 1)) && (col_cur >= ColW'(N_SIZE - 1));
      frame_done_d = last_col && last_row;
      col_d        = last_col ? '0 : col_cur + ColW'(1);
      row_d        = last_col ? (last_row ? '0 : row_cur + RowW'(1)) : row_cur;
`ifdef WINDOW_COORD_EN
      x_d          = col_cur - ColW'(Half);
      y_d          = row_cur - RowW'(Half);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      out_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
`ifdef WINDOW_COORD_EN
      x_q          <= '0;
      y_q          <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_en_q     <= out_en_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
`ifdef WINDOW_COORD_EN
      x_q          <= x_d;
      y_q          <= y_d;
`endif
    end
  end

  // Line-buffer RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.in_en) begin
      lb_mem[0][col_cur] <= bus.in_pix;
      for (int unsigned k = 1; k < N_SIZE - 1; k++) begin
        lb_mem[k][col_cur] <= lb_rd[k-1];
      end
    end
  end

  assign bus.out_img    = win_q;
  assign bus.out_en     = out_en_q;
  assign bus.frame_done = frame_done_q;
`ifdef WINDOW_COORD_EN
  assign bus.out_x      = x_q;
  assign bus.out_y      = y_q;
`endif

endmodule

// File: tb/tb_color_mask_window_buffer.sv
// Self-checking bench for color_mask_window_buffer: frame-array model plus directed streams.
module tb_color_mask_window_buffer;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = 5;
  localparam int C = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_mask_window_buffer_if #(
    .N_SIZE(N),
    .COLORS(C)
`ifdef WINDOW_COORD_EN
    ,
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H)
`endif
  ) bus ();

  color_mask_window_buffer #(
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .N_SIZE(N),
    .COLORS(C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_fd  = 0;

  // Model: the frame as a 2-D image, written at the stream position of each accepted pixel.
  logic [C:0] img [0:H-1][0:W-1];
  logic [C:0] ew  [0:N-1][0:N-1];
  int         pc = 0, pr = 0, ex = 0, ey = 0;
  logic       exp_en = 1'b0, exp_fd = 1'b0;
  bit         primed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [C:0] pat(input int r, input int c);
    return {1'b1, 2'((r * W + c) % 4)};
  endfunction

  always @(negedge clk) begin
    if (primed) begin
      check("out_en", 32'(bus.out_en), 32'(exp_en));
      check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      if (exp_en) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            check($sformatf("win[%0d][%0d]", i, j), 32'(bus.out_img[i][j]), 32'(ew[i][j]));
          end
        end
`ifdef WINDOW_COORD_EN
        check("out_x", 32'(bus.out_x), 32'(ex));
        check("out_y", 32'(bus.out_y), 32'(ey));
`endif
      end
      if (bus.out_en === 1'b1) n_en++;
      if (bus.frame_done === 1'b1) n_fd++;
    end
    if (reset) begin
      pc = 0; pr = 0; exp_en = 1'b0; exp_fd = 1'b0; primed = 1'b1;
    end else if (bus.in_en) begin
      if (bus.in_sof) begin pc = 0; pr = 0; end
      img[pr][pc] = bus.in_pix;
      exp_en = (pr >= N - 1) && (pc >= N - 1);
      if (exp_en) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            ew[i][j] = img[pr - N + 1 + i][pc - N + 1 + j];
          end
        end
      end
      ex = pc - N / 2;
      ey = pr - N / 2;
      exp_fd = (pc == W - 1) && (pr == H - 1);
      pc++;
      if (pc == W) begin
        pc = 0;
        pr++;
        if (pr == H) pr = 0;
      end
    end else begin
      exp_en = 1'b0;
      exp_fd = 1'b0;
    end
  end

  task automatic step(input bit en, input bit sof, input logic [C:0] pix);
    bus.in_en  = en;
    bus.in_sof = sof;
    bus.in_pix = pix;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input int en_cnt, input int fd_cnt);
    check({name, "_en_pulses"}, 32'(n_en), 32'(en_cnt));
    check({name, "_frame_done"}, 32'(n_fd), 32'(fd_cnt));
  endtask

  function automatic int win_nonzero();
    int nz = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.out_img[i][j] !== '0) nz++;
      end
    end
    return nz;
  endfunction

  initial begin
    reset      = 1'b1;
    bus.in_en  = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_en", 32'(bus.out_en), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_win_nonzero", 32'(win_nonzero()), 32'd0);
    reset = 1'b0;

    // Single frame, continuous enable, pattern pixels with pinned literal window values.
    n_en = 0; n_fd = 0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, p == 0, pat(p / W, p % W));
      if (p == 36) begin
        check("first_en", 32'(bus.out_en), 32'd1);
        check("lit_w00", 32'(bus.out_img[0][0]), 32'h4);
        check("lit_w01", 32'(bus.out_img[0][1]), 32'h5);
        check("lit_w10", 32'(bus.out_img[1][0]), 32'h4);
        check("lit_w23", 32'(bus.out_img[2][3]), 32'h7);
        check("lit_w44", 32'(bus.out_img[4][4]), 32'h4);
`ifdef WINDOW_COORD_EN
        check("lit_x", 32'(bus.out_x), 32'd2);
        check("lit_y", 32'(bus.out_y), 32'd2);
`endif
      end
      if (p == W * H - 1) begin
        check("last_frame_done", 32'(bus.frame_done), 32'd1);
        check("last_en", 32'(bus.out_en), 32'd1);
      end
    end
    step(1'b0, 1'b0, '0);
    check_counts("frame", 8, 1);

    // Same frame with the enable toggling every cycle.
    n_en = 0; n_fd = 0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, p == 0, pat(p / W, p % W));
      step(1'b0, 1'b0, 3'(p));
    end
    check_counts("toggle", 8, 1);

    // Frame abandoned at pixel 20 by a fresh start-of-frame.
    n_en = 0; n_fd = 0;
    for (int p = 0; p < 20; p++) step(1'b1, p == 0, 3'($urandom));
    for (int p = 0; p < W * H; p++) step(1'b1, p == 0, 3'($urandom));
    step(1'b0, 1'b0, '0);
    check_counts("sof_restart", 8, 1);

    // Reset during row 5, then a full frame without in_sof.
    for (int p = 0; p < 44; p++) step(1'b1, p == 0, 3'($urandom));
    reset = 1'b1;
    step(1'b1, 1'b0, 3'($urandom));
    reset = 1'b0;
    check("mid_rst_out_en", 32'(bus.out_en), 32'd0);
    check("mid_rst_win_nonzero", 32'(win_nonzero()), 32'd0);
    n_en = 0; n_fd = 0;
    for (int p = 0; p < W * H; p++) step(1'b1, 1'b0, 3'($urandom));
    step(1'b0, 1'b0, '0);
    check_counts("after_reset", 8, 1);

    // Two back-to-back frames; the second relies on the counter wrap.
    n_en = 0; n_fd = 0;
    for (int p = 0; p < 2 * W * H; p++) step(1'b1, p == 0, 3'($urandom));
    step(1'b0, 1'b0, '0);
    check_counts("two_frames", 16, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
